// File: rtl/univ_mod_counter.sv
// N-bit up/down modulo counter with programmable bound and stride, wrap/saturate
// mode and a registered limit-event flag. Define UMC_LIM_STICKY_EN for a sticky lim_tick.
module univ_mod_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic         sat,
  input  logic [N-1:0] step,
  input  logic [N-1:0] max_val,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         lim_tick
);

  logic [N-1:0] count_q, count_d;
  logic         lim_q, lim_d;
  logic         lim_evt;
  logic [N:0]   sum_ext;

  // Sum is widened one bit so an overflow past 2^N still compares above the bound.
  assign sum_ext = {1'b0, count_q} + {1'b0, step};

  always_comb begin
    count_d = count_q;
    lim_evt = 1'b0;
    if (syn_clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (d > max_val) ? max_val : d;
    end else if (en) begin
      if (count_q > max_val) begin
        count_d = max_val;
        lim_evt = 1'b1;
      end else if (step == '0) begin
        count_d = count_q;
      end else if (up) begin
        if (sum_ext <= {1'b0, max_val}) begin
          count_d = sum_ext[N-1:0];
        end else begin
          count_d = sat ? max_val : '0;
          lim_evt = 1'b1;
        end
      end else begin
        if (step <= count_q) begin
          count_d = count_q - step;
        end else begin
          count_d = sat ? '0 : max_val;
          lim_evt = 1'b1;
        end
      end
    end
  end

  always_comb begin
`ifdef UMC_LIM_STICKY_EN
    lim_d = lim_q;
    if (syn_clr || load) begin
      lim_d = 1'b0;
    end else if (lim_evt) begin
      lim_d = 1'b1;
    end
`else
    lim_d = lim_evt;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      lim_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      lim_q   <= lim_d;
    end
  end

  assign q        = count_q;
  assign lim_tick = lim_q;
  assign max_tick = (count_q == max_val);
  assign min_tick = (count_q == '0);

endmodule
